// File: rtl/psimd_fflags_ctrl.sv
// Sticky FP status controller for the 4-lane PSIMD DLFloat datapath.
// Optional per-lane sticky history is built when PSIMD_FFLAGS_LANE_HIST_EN is defined.
module psimd_fflags_ctrl #(
    parameter int LANES  = 4,
    parameter int NFLAGS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic [LANES-1:0]          lane_mask,
    input  logic [LANES-1:0]          invalid,
    input  logic [LANES-1:0]          div_by_zero,
    input  logic [LANES-1:0]          overflow,
    input  logic [LANES-1:0]          underflow,
    input  logic [LANES-1:0]          inexact,
    input  logic [NFLAGS-1:0]         trap_en,
    input  logic                      csr_req,
    input  logic [1:0]                csr_op,
    input  logic [NFLAGS-1:0]         csr_wdata,
    output logic                      csr_ack,
    output logic [NFLAGS-1:0]         csr_rdata,
    output logic [NFLAGS-1:0]         fflags,
    output logic                      trap_req,
    output logic [2:0]                trap_cause,
    output logic [1:0]                trap_lane,
    input  logic                      trap_ack,
    output logic [7:0]                trap_cnt,
    output logic [LANES*NFLAGS-1:0]   lane_flags
);

    typedef enum logic [0:0] {S_RUN, S_TRAP} state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    // Highest set flag index; NV (bit 4) has top priority.
    function automatic logic [2:0] prio_idx(input logic [NFLAGS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NFLAGS; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [1:0] low_lane(input logic [LANES-1:0][NFLAGS-1:0] f,
                                            input logic [2:0] b);
        logic [1:0] l;
        l = 2'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (f[i][b]) l = 2'(i);
        end
        return l;
    endfunction

    function automatic logic [NFLAGS-1:0] csr_apply(input logic [NFLAGS-1:0] cur,
                                                    input logic [1:0] op,
                                                    input logic [NFLAGS-1:0] wd);
        logic [NFLAGS-1:0] r;
        case (op)
            OP_READ:  r = cur;
            OP_WRITE: r = wd;
            OP_SET:   r = cur | wd;
            default:  r = cur & ~wd;
        endcase
        return r;
    endfunction

    state_t                        state_q, state_d;
    logic                          res_ready_q, res_ready_d;
    logic                          trap_req_q, trap_req_d;
    logic [2:0]                    trap_cause_q, trap_cause_d;
    logic [1:0]                    trap_lane_q, trap_lane_d;
    logic [7:0]                    trap_cnt_q, trap_cnt_d;
    logic [NFLAGS-1:0]             fflags_q, fflags_d;
    logic                          csr_ack_q, csr_ack_d;
    logic [NFLAGS-1:0]             csr_rdata_q, csr_rdata_d;

    logic [LANES-1:0][NFLAGS-1:0]  lf;
    logic [NFLAGS-1:0]             beat_or;
    logic [NFLAGS-1:0]             beat_trap;
    logic                          accept;
    logic                          csr_sample;

    always_comb begin
        beat_or = '0;
        for (int i = 0; i < LANES; i++) begin
            lf[i] = lane_mask[i] ? {invalid[i], div_by_zero[i], overflow[i],
                                    underflow[i], inexact[i]} : '0;
            beat_or = beat_or | lf[i];
        end
    end

    assign accept     = res_valid && res_ready_q;
    assign beat_trap  = beat_or & trap_en;
    // A request still high during its ack cycle must not be taken twice.
    assign csr_sample = csr_req && !csr_ack_q;

    always_comb begin
        state_d      = state_q;
        res_ready_d  = res_ready_q;
        trap_req_d   = trap_req_q;
        trap_cause_d = trap_cause_q;
        trap_lane_d  = trap_lane_q;
        trap_cnt_d   = trap_cnt_q;
        csr_ack_d    = csr_sample;
        csr_rdata_d  = csr_sample ? fflags_q : csr_rdata_q;

        // CSR op first, then beat flags, so a clear never drops same-cycle flags.
        fflags_d = csr_sample ? csr_apply(fflags_q, csr_op, csr_wdata) : fflags_q;
        if (accept) fflags_d = fflags_d | beat_or;

        case (state_q)
            S_RUN: begin
                if (accept && (beat_trap != '0)) begin
                    state_d      = S_TRAP;
                    res_ready_d  = 1'b0;
                    trap_req_d   = 1'b1;
                    trap_cause_d = prio_idx(beat_trap);
                    trap_lane_d  = low_lane(lf, prio_idx(beat_trap));
                end
            end
            default: begin
                if (trap_ack) begin
                    state_d     = S_RUN;
                    res_ready_d = 1'b1;
                    trap_req_d  = 1'b0;
                    if (trap_cnt_q != 8'hFF) trap_cnt_d = trap_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            res_ready_q  <= 1'b1;
            trap_req_q   <= 1'b0;
            trap_cause_q <= '0;
            trap_lane_q  <= '0;
            trap_cnt_q   <= '0;
            fflags_q     <= '0;
            csr_ack_q    <= 1'b0;
            csr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            res_ready_q  <= res_ready_d;
            trap_req_q   <= trap_req_d;
            trap_cause_q <= trap_cause_d;
            trap_lane_q  <= trap_lane_d;
            trap_cnt_q   <= trap_cnt_d;
            fflags_q     <= fflags_d;
            csr_ack_q    <= csr_ack_d;
            csr_rdata_q  <= csr_rdata_d;
        end
    end

`ifdef PSIMD_FFLAGS_LANE_HIST_EN
    logic [LANES-1:0][NFLAGS-1:0]  lane_q, lane_d;
    logic [NFLAGS-1:0]             lane_clr;

    // Write and clear both have op bit 0 set; they scrub the same bits per lane.
    assign lane_clr = (csr_sample && csr_op[0]) ? csr_wdata : '0;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_d[i] = lane_q[i] & ~lane_clr;
            if (accept) lane_d[i] = lane_d[i] | lf[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) lane_q <= '0;
        else        lane_q <= lane_d;
    end

    assign lane_flags = lane_q;
`else
    assign lane_flags = '0;
`endif

    assign res_ready  = res_ready_q;
    assign trap_req   = trap_req_q;
    assign trap_cause = trap_cause_q;
    assign trap_lane  = trap_lane_q;
    assign trap_cnt   = trap_cnt_q;
    assign fflags     = fflags_q;
    assign csr_ack    = csr_ack_q;
    assign csr_rdata  = csr_rdata_q;

endmodule

// File: tb/tb_psimd_fflags_ctrl.sv
// Directed self-checking bench for psimd_fflags_ctrl.
module tb_psimd_fflags_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  lane_mask, invalid, div_by_zero, overflow, underflow, inexact;
    logic [4:0]  trap_en;
    logic        csr_req;
    logic [1:0]  csr_op;
    logic [4:0]  csr_wdata;
    logic        csr_ack;
    logic [4:0]  csr_rdata;
    logic [4:0]  fflags;
    logic        trap_req;
    logic [2:0]  trap_cause;
    logic [1:0]  trap_lane;
    logic        trap_ack;
    logic [7:0]  trap_cnt;
    logic [19:0] lane_flags;

    int checks = 0;
    int failures = 0;
    logic hist;

    psimd_fflags_ctrl dut (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(res_ready),
        .lane_mask(lane_mask), .invalid(invalid), .div_by_zero(div_by_zero),
        .overflow(overflow), .underflow(underflow), .inexact(inexact),
        .trap_en(trap_en), .csr_req(csr_req), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_ack(csr_ack), .csr_rdata(csr_rdata), .fflags(fflags),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_lane(trap_lane),
        .trap_ack(trap_ack), .trap_cnt(trap_cnt), .lane_flags(lane_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_beat();
        res_valid = 1'b0; lane_mask = 4'h0; invalid = 4'h0; div_by_zero = 4'h0;
        overflow = 4'h0; underflow = 4'h0; inexact = 4'h0;
    endtask

    initial begin
`ifdef PSIMD_FFLAGS_LANE_HIST_EN
        hist = 1'b1;
`else
        hist = 1'b0;
`endif
        rst_n = 1'b0; clr_beat(); trap_en = 5'h0; trap_ack = 1'b0;
        csr_req = 1'b0; csr_op = 2'b00; csr_wdata = 5'h0;
        tick(); tick();
        chk("rst_fflags", 32'(fflags), 32'h0);
        chk("rst_trap_req", 32'(trap_req), 32'h0);
        chk("rst_res_ready", 32'(res_ready), 32'h1);
        chk("rst_csr_ack", 32'(csr_ack), 32'h0);
        chk("rst_trap_cnt", 32'(trap_cnt), 32'h0);
        chk("rst_lane_flags", 32'(lane_flags), 32'h0);
        chk("rst_csr_rdata", 32'(csr_rdata), 32'h0);
        rst_n = 1'b1;

        // Inexact on lane 2, no traps enabled
        res_valid = 1'b1; lane_mask = 4'hF; inexact = 4'b0100;
        tick(); clr_beat();
        chk("nx_fflags", 32'(fflags), 32'h01);
        chk("nx_trap_req", 32'(trap_req), 32'h0);
        chk("nx_res_ready", 32'(res_ready), 32'h1);
        chk("nx_lane_flags", 32'(lane_flags), hist ? 32'h400 : 32'h0);

        // Masked-off lane carries the only flag
        res_valid = 1'b1; lane_mask = 4'b1110; div_by_zero = 4'b0001; trap_en = 5'h1F;
        tick(); clr_beat();
        chk("mask_fflags", 32'(fflags), 32'h01);
        chk("mask_trap_req", 32'(trap_req), 32'h0);

        // NV on lane 3 beats OF on lanes 1,3
        trap_en = 5'h18; res_valid = 1'b1; lane_mask = 4'hF;
        overflow = 4'b1010; invalid = 4'b1000;
        tick(); clr_beat();
        chk("trap_req", 32'(trap_req), 32'h1);
        chk("trap_cause", 32'(trap_cause), 32'h4);
        chk("trap_lane", 32'(trap_lane), 32'h3);
        chk("trap_res_ready", 32'(res_ready), 32'h0);
        chk("trap_fflags", 32'(fflags), 32'h15);
        chk("trap_lane_flags", 32'(lane_flags), hist ? 32'hA0480 : 32'h0);

        // Stalled beat plus a CSR read while trapped
        res_valid = 1'b1; lane_mask = 4'hF; underflow = 4'b0001; trap_en = 5'h0;
        csr_req = 1'b1; csr_op = 2'b00;
        tick(); clr_beat(); csr_req = 1'b0;
        chk("trapcsr_ack", 32'(csr_ack), 32'h1);
        chk("trapcsr_rdata", 32'(csr_rdata), 32'h15);
        chk("stall_fflags", 32'(fflags), 32'h15);
        chk("stall_trap_req", 32'(trap_req), 32'h1);
        chk("stall_cause_held", 32'(trap_cause), 32'h4);
        trap_ack = 1'b1;
        tick(); trap_ack = 1'b0;
        chk("ack_trap_req", 32'(trap_req), 32'h0);
        chk("ack_res_ready", 32'(res_ready), 32'h1);
        chk("ack_trap_cnt", 32'(trap_cnt), 32'h1);
        chk("ack_csr_ack_drop", 32'(csr_ack), 32'h0);

        // CSR clear-all with a same-cycle underflow beat
        csr_req = 1'b1; csr_op = 2'b11; csr_wdata = 5'h1F;
        res_valid = 1'b1; lane_mask = 4'hF; underflow = 4'b0001;
        tick(); clr_beat(); csr_req = 1'b0;
        chk("clr_ack", 32'(csr_ack), 32'h1);
        chk("clr_rdata", 32'(csr_rdata), 32'h15);
        chk("clr_fflags", 32'(fflags), 32'h02);
        chk("clr_lane_flags", 32'(lane_flags), hist ? 32'h2 : 32'h0);
        tick();
        chk("clr_ack_single", 32'(csr_ack), 32'h0);

        // Write then read back
        csr_req = 1'b1; csr_op = 2'b01; csr_wdata = 5'h15;
        tick(); csr_req = 1'b0;
        chk("wr_ack", 32'(csr_ack), 32'h1);
        chk("wr_rdata", 32'(csr_rdata), 32'h02);
        chk("wr_fflags", 32'(fflags), 32'h15);
        tick();
        chk("wr_ack_single", 32'(csr_ack), 32'h0);
        chk("wr_lane_flags", 32'(lane_flags), hist ? 32'h2 : 32'h0);
        csr_req = 1'b1; csr_op = 2'b00;
        tick(); csr_req = 1'b0;
        chk("rd_ack", 32'(csr_ack), 32'h1);
        chk("rd_rdata", 32'(csr_rdata), 32'h15);
        tick();
        chk("rd_ack_single", 32'(csr_ack), 32'h0);

        // 256 minimum-occupancy traps on NX lane 0; count is already 1
        trap_en = 5'h01;
        for (int i = 0; i < 256; i++) begin
            res_valid = 1'b1; lane_mask = 4'h1; inexact = 4'h1; trap_ack = 1'b1;
            tick(); clr_beat();
            if (i == 0) begin
                chk("sat_first_req", 32'(trap_req), 32'h1);
                chk("sat_first_cause", 32'(trap_cause), 32'h0);
                chk("sat_first_lane", 32'(trap_lane), 32'h0);
            end
            tick();
            if (i == 0) chk("sat_first_ready", 32'(res_ready), 32'h1);
            if (i == 252) chk("sat_cnt_254", 32'(trap_cnt), 32'd254);
        end
        trap_ack = 1'b0;
        chk("sat_trap_cnt", 32'(trap_cnt), 32'd255);

        // Reset in the middle of a trap
        res_valid = 1'b1; lane_mask = 4'h1; inexact = 4'h1;
        tick(); clr_beat();
        chk("midrst_pre_req", 32'(trap_req), 32'h1);
        rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        chk("midrst_trap_req", 32'(trap_req), 32'h0);
        chk("midrst_res_ready", 32'(res_ready), 32'h1);
        chk("midrst_trap_cnt", 32'(trap_cnt), 32'h0);
        chk("midrst_fflags", 32'(fflags), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
